// File: rtl/gaussian_pkg.sv
// Shared constants and types for the gaussian kernel hook-up and its multi-lane dispatcher.
package gaussian_pkg;

   localparam int HC_LANES_DEFAULT   = 4;
   localparam int HC_LANE_FIFO_DEPTH = 8;
   localparam int HC_LINE_W          = 512;

   typedef logic [HC_LINE_W-1:0] t_hc_line;

   typedef struct packed {
      logic [63:0] beatsIn;
      logic [63:0] beatsOut;
      logic [31:0] stallIn;
      logic [31:0] stallOut;
   } t_hc_perf;

endpackage

// File: rtl/hc_lane_fifo.sv
// Per-lane result FIFO: synchronous write and pop, head always visible; the caller never
// writes when full nor pops when empty.
module hc_lane_fifo #(
   parameter int DATA_W = 512,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wrEn,
   input  logic [DATA_W-1:0] wrData,
   input  logic              rdEn,
   output logic              empty,
   output logic              full,
   output logic [DATA_W-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W:0]    wrPtr, rdPtr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (wrEn) wrPtr <= wrPtr + 1'b1;
         if (rdEn) rdPtr <= rdPtr + 1'b1;
      end
   end

   // NOTE: storage is not reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (wrEn) mem[wrPtr[PTR_W-1:0]] <= wrData;
   end

   assign empty = (wrPtr == rdPtr);
   assign full  = (wrPtr[PTR_W] != rdPtr[PTR_W]) && (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
   assign head  = mem[rdPtr[PTR_W-1:0]];

endmodule

// File: rtl/hc_kernel_dispatch.sv
// Round-robin fan-out of a cache-line stream to N_LANES kernels with credit-limited, in-order
// result collection. Perf counters are built only when HC_DISPATCH_PERF_EN is defined.
module hc_kernel_dispatch
   import gaussian_pkg::*;
#(
   parameter int N_LANES    = HC_LANES_DEFAULT,
   parameter int DATA_W     = $bits(t_hc_line),
   parameter int FIFO_DEPTH = HC_LANE_FIFO_DEPTH
) (
   input  logic                                     clk,
   input  logic                                     reset_n,
   input  logic [DATA_W-1:0]                        in_data,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   output logic [N_LANES*DATA_W-1:0]                lane_data_out,
   output logic [N_LANES-1:0]                       lane_valid_out,
   input  logic [N_LANES*DATA_W-1:0]                lane_data_in,
   input  logic [N_LANES-1:0]                       lane_valid_in,
   output logic [DATA_W-1:0]                        out_data,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [$clog2(N_LANES*FIFO_DEPTH+1)-1:0]  inflight,
   output logic                                     overflow_err
`ifdef HC_DISPATCH_PERF_EN
   ,
   output logic [63:0]                              perf_beats_in,
   output logic [63:0]                              perf_beats_out,
   output logic [31:0]                              perf_stall_in,
   output logic [31:0]                              perf_stall_out
`endif
);

   localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int INF_W  = $clog2(N_LANES*FIFO_DEPTH + 1);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);

   logic [LANE_W-1:0]  wrLane, rdLane;
   logic [CNT_W-1:0]   outstanding [N_LANES];
   logic [CNT_W-1:0]   outstandingNext [N_LANES];
   logic [CNT_W-1:0]   pending [N_LANES];
   logic [CNT_W-1:0]   pendingNext [N_LANES];
   logic [INF_W-1:0]   inflightNext;
   logic [N_LANES-1:0] fifoEmpty, fifoFull, fifoWr, fifoRd, dispHit, badResult;
   logic [DATA_W-1:0]  fifoHead [N_LANES];
   logic               accept, load;

   assign in_ready = outstanding[wrLane] < CNT_W'(FIFO_DEPTH);
   assign accept   = in_valid && in_ready;
   assign load     = (!out_valid || out_ready) && !fifoEmpty[rdLane];

   // NOTE: every always_comb output is given a value on every path so no latch is inferred.
   always_comb begin
      inflightNext = '0;
      for (int l = 0; l < N_LANES; l++) begin
         dispHit[l]   = accept && (wrLane == LANE_W'(l));
         fifoRd[l]    = load && (rdLane == LANE_W'(l));
         // A result is legitimate only if the lane still owes one and has room for it.
         fifoWr[l]    = lane_valid_in[l] && !fifoFull[l] && (pending[l] != '0);
         badResult[l] = lane_valid_in[l] && !fifoWr[l];
         outstandingNext[l] = outstanding[l] + CNT_W'(dispHit[l]) - CNT_W'(fifoRd[l]);
         pendingNext[l]     = pending[l] + CNT_W'(dispHit[l]) - CNT_W'(fifoWr[l]);
         inflightNext       = inflightNext + INF_W'(outstandingNext[l]);
      end
   end

   for (genvar l = 0; l < N_LANES; l++) begin : gLane
      hc_lane_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) uFifo (
         .clk    (clk),
         .reset_n(reset_n),
         .wrEn   (fifoWr[l]),
         .wrData (lane_data_in[l*DATA_W +: DATA_W]),
         .rdEn   (fifoRd[l]),
         .empty  (fifoEmpty[l]),
         .full   (fifoFull[l]),
         .head   (fifoHead[l])
      );
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrLane         <= '0;
         rdLane         <= '0;
         lane_valid_out <= '0;
         lane_data_out  <= '0;
         out_valid      <= 1'b0;
         out_data       <= '0;
         inflight       <= '0;
         overflow_err   <= 1'b0;
         for (int l = 0; l < N_LANES; l++) begin
            outstanding[l] <= '0;
            pending[l]     <= '0;
         end
      end else begin
         lane_valid_out <= dispHit;
         if (accept) begin
            lane_data_out[wrLane*DATA_W +: DATA_W] <= in_data;
            wrLane <= (wrLane == LAST_LANE) ? '0 : wrLane + 1'b1;
         end
         if (load) begin
            out_data <= fifoHead[rdLane];
            rdLane   <= (rdLane == LAST_LANE) ? '0 : rdLane + 1'b1;
         end
         out_valid    <= load || (out_valid && !out_ready);
         inflight     <= inflightNext;
         overflow_err <= overflow_err || (|badResult);
         for (int l = 0; l < N_LANES; l++) begin
            outstanding[l] <= outstandingNext[l];
            pending[l]     <= pendingNext[l];
         end
      end
   end

`ifdef HC_DISPATCH_PERF_EN
   t_hc_perf perf;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf <= '0;
      end else begin
         if (accept)                   perf.beatsIn  <= perf.beatsIn + 64'd1;
         if (out_valid && out_ready)   perf.beatsOut <= perf.beatsOut + 64'd1;
         if (in_valid && !in_ready)    perf.stallIn  <= perf.stallIn + 32'd1;
         if (out_valid && !out_ready)  perf.stallOut <= perf.stallOut + 32'd1;
      end
   end

   assign perf_beats_in  = perf.beatsIn;
   assign perf_beats_out = perf.beatsOut;
   assign perf_stall_in  = perf.stallIn;
   assign perf_stall_out = perf.stallOut;
`endif

endmodule

// File: tb/tb_hc_kernel_dispatch.sv
// Scoreboard bench for hc_kernel_dispatch: modelled kernels per lane, expected results queued
// at accept time and compared by an independent output monitor.
module tb_hc_kernel_dispatch;

   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int DW    = 32;
   localparam int INF_W = $clog2(N*DEPTH + 1);

   typedef struct {
      int            due;
      logic [DW-1:0] d;
   } kitem_t;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [DW-1:0]     in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [N*DW-1:0]   lane_data_out;
   logic [N-1:0]      lane_valid_out;
   logic [N*DW-1:0]   lane_data_in;
   logic [N-1:0]      lane_valid_in;
   logic [DW-1:0]     out_data;
   logic              out_valid;
   logic              out_ready;
   logic [INF_W-1:0]  inflight;
   logic              overflow_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [DW-1:0] expQ [$];
   logic [DW-1:0] laneQ [N][$];
   kitem_t        kq [N][$];
   int            lat [N];
   int            wrModel = 0;
   int            readyMode = 0;
   bit            noiseEn = 1'b0;
   bit            injectReq = 1'b0;
   int            injectLane = 0;
   int            firstAcceptCyc = -1;
   int            firstOutCyc = -1;

   hc_kernel_dispatch #(.N_LANES(N), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .lane_data_out (lane_data_out),
      .lane_valid_out(lane_valid_out),
      .lane_data_in  (lane_data_in),
      .lane_valid_in (lane_valid_in),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .inflight      (inflight),
      .overflow_err  (overflow_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // The kernel's transform; any bijection-like function makes reordering errors visible.
   function automatic logic [DW-1:0] kern(input logic [DW-1:0] x);
      return (x << 1) + x + DW'(1);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Kernel models: fixed latency per lane, results fed back without backpressure.
   initial begin : kernels
      kitem_t        it;
      logic [DW-1:0] got;
      lane_valid_in = '0;
      lane_data_in  = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            for (int l = 0; l < N; l++) kq[l].delete();
            lane_valid_in = noiseEn ? N'($urandom) : '0;
            lane_data_in  = {N{DW'($urandom)}};
         end else begin
            lane_valid_in = '0;
            for (int l = 0; l < N; l++) begin
               if (lane_valid_out[l]) begin
                  got = lane_data_out[l*DW +: DW];
                  if (laneQ[l].size() == 0) check($sformatf("lane%0d_spurious", l), 1, 0);
                  else check($sformatf("lane%0d_data", l), got, laneQ[l].pop_front());
                  it.due = cyc + lat[l];
                  it.d   = kern(got);
                  kq[l].push_back(it);
               end
               if (kq[l].size() != 0 && kq[l][0].due <= cyc) begin
                  it = kq[l].pop_front();
                  lane_valid_in[l] = 1'b1;
                  lane_data_in[l*DW +: DW] = it.d;
               end
            end
            if (injectReq) begin
               lane_valid_in[injectLane] = 1'b1;
               lane_data_in[injectLane*DW +: DW] = DW'($urandom);
               injectReq = 1'b0;
            end
         end
      end
   end

   // Output monitor: drives out_ready and compares every handshake against the scoreboard.
   initial begin : monitor
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         case (readyMode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
         if (reset_n && out_valid) begin
            if (firstOutCyc < 0) firstOutCyc = cyc;
            if (out_ready) begin
               if (expQ.size() == 0) check("out_spurious", 1, 0);
               else check("out_data", out_data, expQ.pop_front());
            end
         end
      end
   end

   task automatic sendBeats(input int n, input bit seq, input int base, input int pct,
                            input int budget, output int sent);
      logic [DW-1:0] d;
      int cycles;
      cycles = 0;
      sent = 0;
      d = seq ? DW'(base) : DW'($urandom);
      while (sent < n && cycles < budget) begin
         @(negedge clk);
         cycles++;
         in_valid = ($urandom_range(0, 99) < pct);
         in_data  = d;
         if (in_valid && in_ready) begin
            if (firstAcceptCyc < 0) firstAcceptCyc = cyc;
            expQ.push_back(kern(d));
            laneQ[wrModel].push_back(d);
            wrModel = (wrModel + 1) % N;
            sent++;
            d = seq ? DW'(base + sent) : DW'($urandom);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int b;
      b = 0;
      while (expQ.size() != 0 && b < 2000) begin
         @(negedge clk);
         b++;
      end
      check({name, "_drained"}, expQ.size(), 0);
      repeat (3) @(negedge clk);
      check({name, "_inflight0"}, inflight, 0);
   endtask

   task automatic doReset(input bit noise);
      @(negedge clk);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      noiseEn  = noise;
      expQ.delete();
      for (int l = 0; l < N; l++) laneQ[l].delete();
      wrModel = 0;
      repeat (5) @(negedge clk);
      noiseEn = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int sent;
      for (int l = 0; l < N; l++) lat[l] = 3;

      // Reset with kernel noise on lane_valid_in.
      doReset(1'b1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_lane_valid", lane_valid_out, 0);
      check("rst_lane_data", lane_data_out, 0);
      check("rst_inflight", inflight, 0);
      check("rst_overflow", overflow_err, 0);
      check("rst_in_ready", in_ready, 1);

      // In-order fan-out, equal latency 3.
      firstAcceptCyc = -1;
      firstOutCyc = -1;
      sendBeats(16, 1'b1, 0, 100, 200, sent);
      check("fanout_sent", sent, 16);
      drain("fanout");
      check("fanout_latency", firstOutCyc - firstAcceptCyc, 1 + 3 + 2);

      // Reorder across unequal lane latencies.
      lat = '{9, 2, 5, 1};
      sendBeats(8, 1'b1, 0, 100, 200, sent);
      check("reorder_sent", sent, 8);
      drain("reorder");

      // Backpressure: credits fill, plus one beat parked in the output register.
      for (int l = 0; l < N; l++) lat[l] = 2;
      readyMode = 2;
      sendBeats(20, 1'b1, 0, 100, 60, sent);
      check("bp_accepts", sent, N*DEPTH + 1);
      check("bp_inflight", inflight, N*DEPTH);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      readyMode = 0;
      sendBeats(20 - sent, 1'b1, sent, 100, 200, sent);
      check("bp_rest_sent", sent, 20 - (N*DEPTH + 1));
      drain("bp");
      check("bp_no_err", overflow_err, 0);

      // Randomised traffic, latencies and consumer stalls.
      for (int l = 0; l < N; l++) lat[l] = $urandom_range(1, 8);
      readyMode = 1;
      sendBeats(150, 1'b0, 0, 70, 3000, sent);
      check("rand_sent", sent, 150);
      readyMode = 0;
      drain("rand");
      check("rand_no_err", overflow_err, 0);

      // Spurious result on an idle lane.
      for (int l = 0; l < N; l++) lat[l] = 3;
      @(negedge clk);
      injectLane = 2;
      injectReq  = 1'b1;
      repeat (3) @(negedge clk);
      check("err_set", overflow_err, 1);
      sendBeats(8, 1'b1, 100, 100, 200, sent);
      check("err_stream_sent", sent, 8);
      drain("err_stream");
      check("err_sticky", overflow_err, 1);

      // Reset mid-operation discards in-flight beats and clears the error.
      readyMode = 2;
      sendBeats(6, 1'b1, 200, 100, 100, sent);
      check("mid_sent", sent, 6);
      doReset(1'b0);
      check("mid_rst_err", overflow_err, 0);
      check("mid_rst_inflight", inflight, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      readyMode = 0;
      sendBeats(4, 1'b1, 300, 100, 100, sent);
      check("post_rst_sent", sent, 4);
      drain("post_rst");
      check("post_rst_no_err", overflow_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
